// File: rtl/mod_exp_engine.sv
// Modular exponentiation engine: result = base^exp mod modulus.
// Left-to-right square-and-multiply on top of a word-serial Montgomery
// multiplier (CIOS, one digit per cycle). Operands enter and leave the
// Montgomery domain internally; leading exponent zeros are skipped.
module mod_exp_engine #(
  parameter int WIDTH     = 256,
  parameter int WORD      = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     modulus,
  input  logic [WORD-1:0]      mp,
  input  logic [WIDTH-1:0]     r2,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WIDTH-1:0]     result
);

  localparam int NW = WIDTH / WORD;
  localparam int TW = WIDTH + WORD + 2;     // accumulator width, holds t < 2^(WIDTH+WORD+1)
  localparam int SW = $clog2(NW + 1);       // digit step counter, counts 0..NW
  localparam int BW = $clog2(EXP_WIDTH + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_TOM1, S_TOM2, S_SCAN, S_SQR, S_MUL, S_NEXT, S_FROM, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0]     base_reg, mod_reg, r2_reg, xm_reg, acc_reg, result_reg;
  logic [EXP_WIDTH-1:0] exp_reg;
  logic [WORD-1:0]      mp_reg;
  logic [BW-1:0]        bits_reg, bits_dec;
  logic [SW-1:0]        step_reg;
  logic [TW-1:0]        t_reg;
  logic                 error_reg;

  logic [WIDTH-1:0]     mm_a, mm_b, mm_out;
  logic [WORD-1:0]      b_word, m_word;
  logic [TW-1:0]        t_acc, t_red, t_next;
  logic                 mm_state, mm_last, exp_msb;

  assign result   = result_reg;
  assign error    = error_reg;
  assign bits_dec = bits_reg - BW'(1);
  assign exp_msb  = exp_reg[EXP_WIDTH-1];
  assign mm_last  = (step_reg == SW'(NW));
  assign mm_state = (state_reg == S_TOM1) || (state_reg == S_TOM2) || (state_reg == S_SQR) ||
                    (state_reg == S_MUL)  || (state_reg == S_FROM);

  // Multiplier operand routing: each multiply state owns a fixed (a, b) pair.
  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (state_reg)
      S_TOM1: begin mm_a = base_reg; mm_b = r2_reg;      end
      S_TOM2: begin mm_a = r2_reg;   mm_b = WIDTH'(1);   end
      S_SQR:  begin mm_a = acc_reg;  mm_b = acc_reg;     end
      S_MUL:  begin mm_a = acc_reg;  mm_b = xm_reg;      end
      S_FROM: begin mm_a = acc_reg;  mm_b = WIDTH'(1);   end
      default: begin mm_a = '0;      mm_b = '0;          end
    endcase
  end

  // One CIOS digit step plus the final conditional subtraction.
  always_comb begin
    b_word = WORD'(mm_b >> (WORD * int'(step_reg)));
    t_acc  = t_reg + TW'(mm_a) * TW'(b_word);
    m_word = t_acc[WORD-1:0] * mp_reg;
    t_red  = t_acc + TW'(m_word) * TW'(mod_reg);
    t_next = t_red >> WORD;
    mm_out = WIDTH'((t_reg >= TW'(mod_reg)) ? (t_reg - TW'(mod_reg)) : t_reg);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: if (start) state_next = S_LOAD;
      S_LOAD: state_next = mod_reg[0] ? S_TOM1 : S_DONE;
      S_TOM1: if (mm_last) state_next = S_TOM2;
      S_TOM2: if (mm_last) state_next = S_SCAN;
      S_SCAN: begin
        // A set MSB is the leading one: its cycle is the acc = xm copy.
        if (exp_msb) state_next = (bits_dec != '0) ? S_SQR : S_FROM;
        else if (bits_dec == '0) state_next = S_FROM;
      end
      S_SQR:  if (mm_last) state_next = exp_msb ? S_MUL : S_NEXT;
      S_MUL:  if (mm_last) state_next = S_NEXT;
      S_NEXT: state_next = (bits_dec != '0) ? S_SQR : S_FROM;
      S_FROM: if (mm_last) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    busy = (state_reg != S_IDLE) && (state_reg != S_DONE);
    done = (state_reg == S_DONE);
  end

  // Operand capture, exponent walk and multiplier datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_reg   <= '0;
      mod_reg    <= '0;
      r2_reg     <= '0;
      mp_reg     <= '0;
      exp_reg    <= '0;
      bits_reg   <= '0;
      xm_reg     <= '0;
      acc_reg    <= '0;
      t_reg      <= '0;
      step_reg   <= '0;
      result_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          base_reg   <= base;
          mod_reg    <= modulus;
          r2_reg     <= r2;
          mp_reg     <= mp;
          exp_reg    <= exp;
          bits_reg   <= BW'(EXP_WIDTH);
          t_reg      <= '0;
          step_reg   <= '0;
          result_reg <= '0;
          error_reg  <= 1'b0;
        end
        S_LOAD: if (!mod_reg[0]) begin
          error_reg  <= 1'b1;
          result_reg <= '0;
        end
        S_SCAN, S_NEXT: begin
          exp_reg  <= exp_reg << 1;
          bits_reg <= bits_dec;
          if ((state_reg == S_SCAN) && exp_msb) acc_reg <= xm_reg;
        end
        default: if (mm_state) begin
          if (mm_last) begin
            t_reg    <= '0;
            step_reg <= '0;
            case (state_reg)
              S_TOM1:  xm_reg     <= mm_out;
              S_FROM:  result_reg <= mm_out;
              default: acc_reg    <= mm_out;
            endcase
          end else begin
            t_reg    <= t_next;
            step_reg <= step_reg + SW'(1);
          end
        end
      endcase
    end
  end

endmodule
